// File: rtl/filter_read_sequencer_if.sv
// rtl/filter_read_sequencer_if.sv - beat stream from the filter read sequencer to its consumer
interface filter_read_sequencer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int I_WIDTH    = 4,
  parameter int NF_WIDTH   = 4
);
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] current_filter_start_addr;
  logic [I_WIDTH-1:0]    i;
  logic                  is_second_filter;
  logic [NF_WIDTH-1:0]   filter_idx;

  modport master (
    output out_valid, current_filter_start_addr, i, is_second_filter, filter_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid, current_filter_start_addr, i, is_second_filter, filter_idx,
    output out_ready
  );
endinterface

// File: rtl/filter_read_sequencer.sv
// rtl/filter_read_sequencer.sv - walks every element of every filter, plain or pairwise interleaved
module filter_read_sequencer #(
  parameter int ADDR_WIDTH = 16,
  parameter int I_WIDTH    = 4,
  parameter int NF_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [I_WIDTH-1:0]    filter_size,
  input  logic [NF_WIDTH-1:0]   num_filters,
  input  logic                  interleaved_mode,
  filter_read_sequencer_if.master beat,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [I_WIDTH-1:0]    i_q, i_d, fsize_q;
  logic [NF_WIDTH-1:0]   fidx_q, fidx_d, nf_q, even_idx;
  logic                  sec_q, sec_d, ilv_q;
  logic                  valid_q, busy_q, done_q, last_d;
  logic                  i_last;
  logic [NF_WIDTH:0]     pair_next;

  assign i_last   = (i_q == fsize_q - I_WIDTH'(1));
  assign even_idx = sec_q ? fidx_q - NF_WIDTH'(1) : fidx_q;

  // Next beat position; last_d marks the beat after which the walk ends.
  always_comb begin
    addr_d    = addr_q;
    i_d       = i_q;
    sec_d     = sec_q;
    fidx_d    = fidx_q;
    last_d    = 1'b0;
    pair_next = '0;
    if (!ilv_q) begin
      if (!i_last) begin
        i_d = i_q + I_WIDTH'(1);
      end else begin
        i_d    = '0;
        addr_d = addr_q + ADDR_WIDTH'(fsize_q);
        fidx_d = fidx_q + NF_WIDTH'(1);
        last_d = (fidx_q == nf_q - NF_WIDTH'(1));
      end
    end else if (!sec_q && (fidx_q != nf_q - NF_WIDTH'(1))) begin
      sec_d  = 1'b1;
      fidx_d = fidx_q + NF_WIDTH'(1);
    end else begin
      // Second beat done, or skipped for an odd leftover filter.
      sec_d = 1'b0;
      if (!i_last) begin
        i_d    = i_q + I_WIDTH'(1);
        fidx_d = even_idx;
      end else begin
        i_d       = '0;
        addr_d    = addr_q + ADDR_WIDTH'({fsize_q, 1'b0});
        pair_next = {1'b0, even_idx} + (NF_WIDTH+1)'(2);
        fidx_d    = pair_next[NF_WIDTH-1:0];
        last_d    = (pair_next >= {1'b0, nf_q});
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      i_q     <= '0;
      sec_q   <= 1'b0;
      fidx_q  <= '0;
      fsize_q <= '0;
      nf_q    <= '0;
      ilv_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            fsize_q <= filter_size;
            nf_q    <= num_filters;
            ilv_q   <= interleaved_mode;
            addr_q  <= base_addr;
            i_q     <= '0;
            sec_q   <= 1'b0;
            fidx_q  <= '0;
            busy_q  <= 1'b1;
            if (filter_size == '0 || num_filters == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              valid_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (beat.out_ready) begin
            addr_q <= addr_d;
            i_q    <= i_d;
            sec_q  <= sec_d;
            fidx_q <= fidx_d;
            if (last_d) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign beat.out_valid                 = valid_q;
  assign beat.current_filter_start_addr = addr_q;
  assign beat.i                         = i_q;
  assign beat.is_second_filter          = sec_q;
  assign beat.filter_idx                = fidx_q;
  assign busy                           = busy_q;
  assign done                           = done_q;
endmodule

// File: tb/tb_filter_read_sequencer.sv
// tb/tb_filter_read_sequencer.sv - self-checking bench for filter_read_sequencer
module tb_filter_read_sequencer;
  typedef struct {
    logic [15:0] addr;
    logic [3:0]  i;
    logic        sec;
    logic [3:0]  fidx;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [3:0]  filter_size = '0;
  logic [3:0]  num_filters = '0;
  logic        interleaved_mode = 1'b0;
  logic        busy, done;

  filter_read_sequencer_if #(.ADDR_WIDTH(16), .I_WIDTH(4), .NF_WIDTH(4)) bus ();

  filter_read_sequencer #(.ADDR_WIDTH(16), .I_WIDTH(4), .NF_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .filter_size(filter_size), .num_filters(num_filters),
    .interleaved_mode(interleaved_mode), .beat(bus.master),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int    tests = 0;
  int    fails = 0;
  beat_t exp_q[$];
  beat_t obs_q[$];
  beat_t prev;
  logic  prev_stall = 1'b0;
  logic  chk_en = 1'b0;
  logic  done_due = 1'b0;
  logic  bp_en = 1'b0;
  logic  pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int ph = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = bp_en ? pat[ph] : 1'b1;
      ph = (ph + 1) % 4;
    end
  end

  // Compare process: every cycle the DUT must show the head of the model queue.
  always @(negedge clk) begin
    beat_t cur;
    if (chk_en) begin
      chk("done", done, done_due);
      done_due = 1'b0;
      cur.addr = bus.current_filter_start_addr;
      cur.i    = bus.i;
      cur.sec  = bus.is_second_filter;
      cur.fidx = bus.filter_idx;
      if (bus.out_valid) begin
        if (prev_stall) begin
          chk("hold_addr", cur.addr, prev.addr);
          chk("hold_i", cur.i, prev.i);
          chk("hold_fidx", cur.fidx, prev.fidx);
        end
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          chk("addr", cur.addr, exp_q[0].addr);
          chk("i", cur.i, exp_q[0].i);
          chk("is_second", cur.sec, exp_q[0].sec);
          chk("filter_idx", cur.fidx, exp_q[0].fidx);
          chk("busy_run", busy, 1);
          if (bus.out_ready) begin
            obs_q.push_back(cur);
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) done_due = 1'b1;
          end
        end
        prev       = cur;
        prev_stall = !bus.out_ready;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic build_model(input logic [15:0] b, input int fs, input int nf, input logic ilv);
    beat_t x;
    exp_q.delete();
    obs_q.delete();
    if (!ilv) begin
      for (int f = 0; f < nf; f++)
        for (int e = 0; e < fs; e++) begin
          x.addr = b + 16'(f * fs); x.i = 4'(e); x.sec = 1'b0; x.fidx = 4'(f);
          exp_q.push_back(x);
        end
    end else begin
      for (int p = 0; p < nf; p += 2)
        for (int e = 0; e < fs; e++) begin
          x.addr = b + 16'(p * fs); x.i = 4'(e); x.sec = 1'b0; x.fidx = 4'(p);
          exp_q.push_back(x);
          if (p + 1 < nf) begin
            x.sec = 1'b1; x.fidx = 4'(p + 1);
            exp_q.push_back(x);
          end
        end
    end
  endtask

  task automatic launch(input logic [15:0] b, input int fs, input int nf, input logic ilv);
    build_model(b, fs, nf, ilv);
    @(posedge clk);
    #1;
    base_addr = b; filter_size = 4'(fs); num_filters = 4'(nf); interleaved_mode = ilv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    base_addr = 16'hDEAD; filter_size = 4'hF; num_filters = 4'hF; interleaved_mode = ~ilv;
  endtask

  task automatic wait_done();
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < 500) begin
      @(negedge clk);
      seen = done;
      n++;
    end
    chk("done_seen", seen, 1);
    chk("model_drained", exp_q.size(), 0);
    @(negedge clk);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_addr", bus.current_filter_start_addr, 0);
    chk("rst_i", bus.i, 0);
    chk("rst_sec", bus.is_second_filter, 0);
    chk("rst_fidx", bus.filter_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    launch(16'h0100, 3, 2, 1'b0);
    wait_done();
    chk("plain_count", obs_q.size(), 6);
    chk("plain_b3_addr", obs_q[3].addr, 16'h0103);
    chk("plain_b5_i", obs_q[5].i, 2);
    chk("plain_b4_fidx", obs_q[4].fidx, 1);

    launch(16'h0020, 2, 2, 1'b1);
    wait_done();
    chk("ilv_count", obs_q.size(), 4);
    chk("ilv_b1_sec", obs_q[1].sec, 1);
    chk("ilv_b2_fidx", obs_q[2].fidx, 0);
    chk("ilv_b3_addr", obs_q[3].addr, 16'h0020);

    launch(16'h0000, 2, 3, 1'b1);
    wait_done();
    chk("odd_count", obs_q.size(), 6);
    chk("odd_b4_addr", obs_q[4].addr, 16'h0004);
    chk("odd_b5_fidx", obs_q[5].fidx, 2);
    chk("odd_b5_sec", obs_q[5].sec, 0);

    bp_en = 1'b1;
    launch(16'h0040, 3, 2, 1'b0);
    wait_done();
    bp_en = 1'b0;
    chk("bp_count", obs_q.size(), 6);

    launch(16'hFFFE, 4, 2, 1'b0);
    wait_done();
    chk("wrap_b4_addr", obs_q[4].addr, 16'h0002);

    chk_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      base_addr = 16'h0010; interleaved_mode = 1'b0;
      filter_size = (k == 0) ? 4'd0 : 4'd3;
      num_filters = (k == 0) ? 4'd2 : 4'd0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk("degen_done", done, 1);
      chk("degen_valid", bus.out_valid, 0);
      @(negedge clk);
      chk("degen_done_off", done, 0);
      chk("degen_valid_off", bus.out_valid, 0);
      chk("degen_busy_off", busy, 0);
    end
    @(negedge clk);
    done_due = 1'b0;
    prev_stall = 1'b0;
    chk_en = 1'b1;

    launch(16'h0100, 3, 2, 1'b0);
    n = 0;
    while (obs_q.size() < 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("reach_beat2", obs_q.size(), 2);
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_addr", bus.current_filter_start_addr, 0);
    chk("mid_rst_i", bus.i, 0);
    chk("mid_rst_fidx", bus.filter_idx, 0);
    chk("mid_rst_busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_rst_no_done", done, 0);
    end
    rst_n = 1'b1;
    exp_q.delete();
    done_due = 1'b0;
    prev_stall = 1'b0;
    @(negedge clk);
    chk("post_rst_no_done", done, 0);
    chk_en = 1'b1;
    launch(16'h0100, 3, 2, 1'b0);
    wait_done();
    chk("rerun_count", obs_q.size(), 6);
    chk("rerun_b0_addr", obs_q[0].addr, 16'h0100);
    chk("rerun_b0_i", obs_q[0].i, 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/filter_read_sequencer.md
Name: filter_read_sequencer

Overview:
- Upstream control stage for the filter read address generator.
- Walks every element of every filter in the filter scratchpad, in plain or interleaved layout.
- Each beat presents current_filter_start_addr, i and is_second_filter; the downstream generator turns these into a read address combinationally.
- A valid/ready handshake lets the consuming PE stall the walk.

Parameters:
ADDR_WIDTH, 16, width of scratchpad addresses
I_WIDTH, 4, width of element index i and of filter_size
NF_WIDTH, 4, width of filter count and filter index

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a walk; sampled only in IDLE
base_addr  input  ADDR_WIDTH  start address of filter 0; latched on accepted start
filter_size  input  I_WIDTH  elements per filter; latched on accepted start
num_filters  input  NF_WIDTH  number of filters to walk; latched on accepted start
interleaved_mode  input  1  1 = filters stored pairwise interleaved; latched on accepted start
out_ready  input  1  consumer accepts current beat
out_valid  output  1  beat fields valid
current_filter_start_addr  output  ADDR_WIDTH  start address of the current filter (plain mode) or filter pair (interleaved mode)
i  output  I_WIDTH  element index within filter
is_second_filter  output  1  beat belongs to odd filter of an interleaved pair
filter_idx  output  NF_WIDTH  index of filter the beat belongs to
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse at end of walk

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0: out_valid, current_filter_start_addr, i, is_second_filter, filter_idx, busy, done.
- Reset mid-walk aborts immediately with no done pulse.

FSM states:
- IDLE:
  - start=1 latches the config.
  - Sets start addr = base_addr, i=0, is_second_filter=0, filter_idx=0.
  - Goes to RUN, or to DONE directly if filter_size==0 or num_filters==0.
  - out_valid asserts the cycle after start, so there is one-cycle latency.
- RUN:
  - out_valid=1.
  - A beat transfers on out_valid && out_ready. On that edge the beat advances as described below.
  - While out_ready=0, all beat fields hold stable.
  - start is ignored.
- DONE: done=1 for exactly one cycle, out_valid=0, then IDLE.

Beat advance, plain mode (interleaved_mode=0):
- If i < filter_size-1: i++.
- Else:
  - i=0.
  - start addr += filter_size, zero-extended.
  - filter_idx++.
  - If filter_idx was num_filters-1, go to DONE instead.

Beat advance, interleaved mode:
- Beats are ordered (i, first filter), (i, second filter), then i+1.
- After a first-filter beat: set is_second_filter=1 and filter_idx++. The exception is when filter_idx==num_filters-1 (odd leftover filter): then the second beat is skipped and the walk proceeds as if the second-filter beat had completed.
- After a second-filter beat (or a skipped one):
  - is_second_filter=0, and filter_idx returns to the even index.
  - If i < filter_size-1: i++.
  - Else:
    - i=0.
    - start addr += 2*filter_size.
    - filter_idx = even index + 2.
    - Go to DONE if that index >= num_filters.

Arithmetic and boundaries:
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no overflow flag.
- 2*filter_size is computed at I_WIDTH+1 bits before zero-extension.
- Latched config is immune to input changes during RUN.
- start asserted in the same cycle as the done pulse is ignored. It is accepted from the following IDLE cycle.

Test Plan:
- Plain walk:
  - Stimulus: base_addr=0x0100, filter_size=3, num_filters=2, out_ready=1.
  - Required: 6 beats (addr,i) = (0x100,0),(0x100,1),(0x100,2),(0x103,0),(0x103,1),(0x103,2); filter_idx 0,0,0,1,1,1; done pulses one cycle after last beat.
- Interleaved walk:
  - Stimulus: base_addr=0x0020, filter_size=2, num_filters=2.
  - Required: beats (i,is_second) = (0,0),(0,1),(1,0),(1,1), all with addr 0x020; filter_idx 0,1,0,1.
- Interleaved odd count:
  - Stimulus: num_filters=3, filter_size=2, base 0.
  - Required:
    - 4 beats at addr 0.
    - Then 2 beats at addr 4 with is_second_filter=0, filter_idx=2.
    - Then done; 6 beats total.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1 during a plain walk.
  - Required: fields constant while out_ready=0; no beat lost or duplicated; beat count matches filter_size*num_filters.
- Degenerate and wrap:
  - Stimulus A: filter_size=0 → no out_valid; done 1 cycle after start.
  - Stimulus B: base_addr=0xFFFE, filter_size=4, num_filters=2 → second filter addr=0x0002.
- Reset mid-walk:
  - Stimulus: assert rst_n=0 during beat 2.
  - Required: all outputs 0 asynchronously and no done pulse; a new start afterwards runs a full walk from beat 0.
